// File: rtl/sal_cmd_sched.sv
// Per-channel DRAM command scheduler: combinational single-grant arbitration across
// bank controllers with inter-bank timing, plus a registered command output stage.
module sal_cmd_sched #(
  parameter int NUM_BK = 8,
  parameter int RA_W   = 16,
  parameter int CA_W   = 10,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int TW     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BK-1:0]          act_req,
  input  logic [NUM_BK-1:0]          rd_req,
  input  logic [NUM_BK-1:0]          wr_req,
  input  logic [NUM_BK-1:0]          pre_req,
  input  logic [NUM_BK-1:0]          ref_req,
  output logic [NUM_BK-1:0]          act_gnt,
  output logic [NUM_BK-1:0]          rd_gnt,
  output logic [NUM_BK-1:0]          wr_gnt,
  output logic [NUM_BK-1:0]          pre_gnt,
  output logic [NUM_BK-1:0]          ref_gnt,
  input  logic [NUM_BK*RA_W-1:0]     bk_ra,
  input  logic [NUM_BK*CA_W-1:0]     bk_ca,
  input  logic [NUM_BK*ID_W-1:0]     bk_id,
  input  logic [NUM_BK*LEN_W-1:0]    bk_len,
  input  logic [TW-1:0]              t_rrd_m1,
  input  logic [TW-1:0]              t_faw_m1,
  input  logic [TW-1:0]              t_ccd_m1,
  input  logic [TW-1:0]              t_wtr_m1,
  input  logic [TW-1:0]              t_rtw_m1,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_type,
  output logic [$clog2(NUM_BK)-1:0]  cmd_ba,
  output logic [RA_W-1:0]            cmd_ra,
  output logic [CA_W-1:0]            cmd_ca,
  output logic [ID_W-1:0]            cmd_id,
  output logic [LEN_W-1:0]           cmd_len
);

  localparam int BA_W = $clog2(NUM_BK);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  // Class indices double as priority order (lower index wins).
  localparam int CL_CAS = 0;
  localparam int CL_PRE = 1;
  localparam int CL_ACT = 2;
  localparam int CL_REF = 3;

  logic [TW-1:0]   rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d;
  logic [TW-1:0]   faw_q [4];
  logic [TW-1:0]   faw_d [4];
  logic [BA_W-1:0] ptr_q [4];
  logic [BA_W-1:0] ptr_d [4];

  logic            cmd_valid_q, cmd_valid_d;
  logic [2:0]      cmd_type_q, cmd_type_d;
  logic [BA_W-1:0] cmd_ba_q, cmd_ba_d;
  logic [RA_W-1:0] cmd_ra_q, cmd_ra_d;
  logic [CA_W-1:0] cmd_ca_q, cmd_ca_d;
  logic [ID_W-1:0] cmd_id_q, cmd_id_d;
  logic [LEN_W-1:0] cmd_len_q, cmd_len_d;

  logic rd_ok, wr_ok, act_ok;
  logic [3:0][NUM_BK-1:0] elig;
  logic [3:0]             pick_found;
  logic [3:0][BA_W-1:0]   pick_idx;

  logic            sel_valid;
  logic [2:0]      sel_type;
  logic [1:0]      sel_cls;
  logic [BA_W-1:0] sel_ba;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

  always_comb begin
    rd_ok  = (ccd_q == '0) && (wtr_q == '0);
    wr_ok  = (ccd_q == '0) && (rtw_q == '0);
    act_ok = (rrd_q == '0) &&
             ((faw_q[0] == '0) || (faw_q[1] == '0) || (faw_q[2] == '0) || (faw_q[3] == '0));
    elig[CL_CAS] = (rd_req & {NUM_BK{rd_ok}}) | (wr_req & {NUM_BK{wr_ok}});
    elig[CL_PRE] = pre_req;
    elig[CL_ACT] = act_req & {NUM_BK{act_ok}};
    elig[CL_REF] = ref_req;
  end

  // Round-robin per class: scan downward so the smallest offset from the pointer wins.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rr
      logic            found;
      logic [BA_W-1:0] idx;
      always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_BK - 1; k >= 0; k--) begin
          if (elig[gi][ptr_q[gi] + BA_W'(k)]) begin
            found = 1'b1;
            idx   = ptr_q[gi] + BA_W'(k);
          end
        end
      end
      assign pick_found[gi] = found;
      assign pick_idx[gi]   = idx;
    end
  endgenerate

  always_comb begin
    sel_valid = 1'b0;
    sel_cls   = 2'd0;
    sel_ba    = '0;
    sel_type  = CMD_NOP;
    if (!rst) begin
      for (int c = 3; c >= 0; c--) begin
        if (pick_found[c]) begin
          sel_valid = 1'b1;
          sel_cls   = 2'(c);
          sel_ba    = pick_idx[c];
        end
      end
    end
    if (sel_valid) begin
      case (sel_cls)
        2'(CL_CAS): sel_type = (rd_req[sel_ba] && rd_ok) ? CMD_RD : CMD_WR;
        2'(CL_PRE): sel_type = CMD_PRE;
        2'(CL_ACT): sel_type = CMD_ACT;
        default:    sel_type = CMD_REF;
      endcase
    end
  end

  always_comb begin
    act_gnt = '0;
    rd_gnt  = '0;
    wr_gnt  = '0;
    pre_gnt = '0;
    ref_gnt = '0;
    case (sel_type)
      CMD_ACT: act_gnt[sel_ba] = 1'b1;
      CMD_RD:  rd_gnt[sel_ba]  = 1'b1;
      CMD_WR:  wr_gnt[sel_ba]  = 1'b1;
      CMD_PRE: pre_gnt[sel_ba] = 1'b1;
      CMD_REF: ref_gnt[sel_ba] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    logic faw_loaded;
    rrd_d = (sel_type == CMD_ACT) ? t_rrd_m1 : dec_sat(rrd_q);
    ccd_d = (sel_type == CMD_RD || sel_type == CMD_WR) ? t_ccd_m1 : dec_sat(ccd_q);
    wtr_d = (sel_type == CMD_WR) ? t_wtr_m1 : dec_sat(wtr_q);
    rtw_d = (sel_type == CMD_RD) ? t_rtw_m1 : dec_sat(rtw_q);
    faw_loaded = 1'b0;
    for (int s = 0; s < 4; s++) begin
      faw_d[s] = dec_sat(faw_q[s]);
      if (sel_type == CMD_ACT && !faw_loaded && faw_q[s] == '0) begin
        faw_d[s]   = t_faw_m1;
        faw_loaded = 1'b1;
      end
    end
    for (int c = 0; c < 4; c++) begin
      ptr_d[c] = ptr_q[c];
    end
    if (sel_valid) begin
      ptr_d[sel_cls] = sel_ba + BA_W'(1);
    end
  end

  // Fields not carried by the command type are driven as zero.
  always_comb begin
    cmd_valid_d = sel_valid;
    cmd_type_d  = sel_type;
    cmd_ba_d    = sel_valid ? sel_ba : '0;
    cmd_ra_d    = '0;
    cmd_ca_d    = '0;
    cmd_id_d    = '0;
    cmd_len_d   = '0;
    if (sel_type == CMD_ACT) begin
      cmd_ra_d = bk_ra[sel_ba*RA_W +: RA_W];
    end
    if (sel_type == CMD_RD || sel_type == CMD_WR) begin
      cmd_ca_d  = bk_ca[sel_ba*CA_W +: CA_W];
      cmd_id_d  = bk_id[sel_ba*ID_W +: ID_W];
      cmd_len_d = bk_len[sel_ba*LEN_W +: LEN_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_q       <= '0;
      ccd_q       <= '0;
      wtr_q       <= '0;
      rtw_q       <= '0;
      for (int s = 0; s < 4; s++) begin
        faw_q[s] <= '0;
        ptr_q[s] <= '0;
      end
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_NOP;
      cmd_ba_q    <= '0;
      cmd_ra_q    <= '0;
      cmd_ca_q    <= '0;
      cmd_id_q    <= '0;
      cmd_len_q   <= '0;
    end else begin
      rrd_q       <= rrd_d;
      ccd_q       <= ccd_d;
      wtr_q       <= wtr_d;
      rtw_q       <= rtw_d;
      for (int s = 0; s < 4; s++) begin
        faw_q[s] <= faw_d[s];
        ptr_q[s] <= ptr_d[s];
      end
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_ra_q    <= cmd_ra_d;
      cmd_ca_q    <= cmd_ca_d;
      cmd_id_q    <= cmd_id_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_ra    = cmd_ra_q;
  assign cmd_ca    = cmd_ca_q;
  assign cmd_id    = cmd_id_q;
  assign cmd_len   = cmd_len_q;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Scoreboard bench for sal_cmd_sched: each stimulus cycle checks grants and queues the
// expected registered command; a monitor pops and compares one entry per clock.
module tb_sal_cmd_sched;

  localparam int NB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NB-1:0]  act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB-1:0]  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [NB*16-1:0] bk_ra;
  logic [NB*10-1:0] bk_ca;
  logic [NB*4-1:0]  bk_id;
  logic [NB*4-1:0]  bk_len;
  logic [7:0]     t_rrd_m1, t_faw_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
  logic           cmd_valid;
  logic [2:0]     cmd_type;
  logic [2:0]     cmd_ba;
  logic [15:0]    cmd_ra;
  logic [9:0]     cmd_ca;
  logic [3:0]     cmd_id;
  logic [3:0]     cmd_len;

  typedef struct packed {
    logic        v;
    logic [2:0]  t;
    logic [2:0]  ba;
    logic [15:0] ra;
    logic [9:0]  ca;
    logic [3:0]  id;
    logic [3:0]  len;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sal_cmd_sched #(.NUM_BK(NB), .RA_W(16), .CA_W(10), .ID_W(4), .LEN_W(4), .TW(8)) dut (
    .clk(clk), .rst(rst),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .bk_ra(bk_ra), .bk_ca(bk_ca), .bk_id(bk_id), .bk_len(bk_len),
    .t_rrd_m1(t_rrd_m1), .t_faw_m1(t_faw_m1), .t_ccd_m1(t_ccd_m1),
    .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
    .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
  );

  // Monitor: one expected output per clock once stimulus has started queueing.
  always @(posedge clk) begin
    cmd_t got, e;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = '{cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cmd_out @%0t: got v=%0b t=%0d ba=%0d ra=%h ca=%h id=%h len=%h, exp v=%0b t=%0d ba=%0d ra=%h ca=%h id=%h len=%h",
                 $time, got.v, got.t, got.ba, got.ra, got.ca, got.id, got.len,
                 e.v, e.t, e.ba, e.ra, e.ca, e.id, e.len);
      end else begin
        $display("cmd_out @%0t: v=%0b t=%0d ba=%0d ok", $time, got.v, got.t, got.ba);
      end
    end
  end

  // One clock of stimulus: gtype 0=none,1=ACT,2=RD,3=WR,4=PRE,5=REF for bank `bank`.
  task automatic cyc(input int gtype, input int bank, input string name);
    logic [5*NB-1:0] exp_g, got_g;
    logic [NB-1:0]   one;
    cmd_t            e;
    @(negedge clk);
    one   = NB'(1) << bank;
    exp_g = '0;
    case (gtype)
      1: exp_g[4*NB +: NB] = one;
      2: exp_g[3*NB +: NB] = one;
      3: exp_g[2*NB +: NB] = one;
      4: exp_g[1*NB +: NB] = one;
      5: exp_g[0 +: NB]    = one;
      default: ;
    endcase
    got_g = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
    checks++;
    if (got_g !== exp_g) begin
      errors++;
      $display("FAIL gnt %s @%0t: got act=%b rd=%b wr=%b pre=%b ref=%b, exp type=%0d bank=%0d",
               name, $time, act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, gtype, bank);
    end else begin
      $display("gnt %s @%0t: type=%0d bank=%0d ok", name, $time, gtype, bank);
    end
    e = '0;
    if (gtype != 0) begin
      e.v  = 1'b1;
      e.t  = 3'(gtype);
      e.ba = 3'(bank);
      if (gtype == 1) e.ra = 16'hA000 + 16'(bank);
      if (gtype == 2 || gtype == 3) begin
        e.ca  = 10'h100 + 10'(bank);
        e.id  = 4'(bank + 3);
        e.len = 4'(15 - bank);
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  task automatic do_reset();
    clr_req();
    rst = 1'b1;
    cyc(0, 0, "reset");
    rst = 1'b0;
  endtask

  task automatic zero_timing();
    t_rrd_m1 = 8'd0; t_faw_m1 = 8'd0; t_ccd_m1 = 8'd0; t_wtr_m1 = 8'd0; t_rtw_m1 = 8'd0;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      bk_ra[i*16 +: 16] = 16'hA000 + 16'(i);
      bk_ca[i*10 +: 10] = 10'h100 + 10'(i);
      bk_id[i*4 +: 4]   = 4'(i + 3);
      bk_len[i*4 +: 4]  = 4'(15 - i);
    end
    zero_timing();

    // Reset hold with everything requesting, then release.
    rst = 1'b1;
    act_req = '1; rd_req = '1; wr_req = '1; pre_req = '1; ref_req = '1;
    for (int i = 0; i < 3; i++) cyc(0, 0, "reset_hold");
    rst = 1'b0;
    cyc(2, 0, "reset_release");
    clr_req();
    cyc(0, 0, "idle");

    // Zero tCCD: RD every cycle, round-robin between banks 0 and 1.
    do_reset();
    rd_req = 8'b0000_0011;
    cyc(2, 0, "rd_b2b_0");
    cyc(2, 1, "rd_b2b_1");
    cyc(2, 0, "rd_b2b_2");
    clr_req();

    // Class priority CAS > PRE > ACT > REF.
    do_reset();
    act_req[2] = 1'b1; rd_req[5] = 1'b1; pre_req[7] = 1'b1; ref_req[4] = 1'b1;
    cyc(2, 5, "prio_rd");
    rd_req = '0;
    cyc(4, 7, "prio_pre");
    pre_req = '0;
    cyc(1, 2, "prio_act");
    act_req = '0;
    cyc(5, 4, "prio_ref");
    ref_req = '0;
    cyc(0, 0, "prio_idle");

    // Round-robin over PRE requests.
    do_reset();
    pre_req = 8'b0000_1111;
    cyc(4, 0, "rr_0");
    cyc(4, 1, "rr_1");
    cyc(4, 2, "rr_2");
    cyc(4, 3, "rr_3");
    cyc(4, 0, "rr_wrap");
    clr_req();

    // tRRD=2 cycles, tFAW=16 cycles window.
    do_reset();
    t_rrd_m1 = 8'd1; t_faw_m1 = 8'd15;
    act_req = '1;
    for (int c = 0; c <= 16; c++) begin
      if (c == 0 || c == 2 || c == 4 || c == 6) cyc(1, c / 2, "rrd_faw");
      else if (c == 16)                          cyc(1, 4, "faw_5th");
      else                                       cyc(0, 0, "rrd_faw_block");
    end
    clr_req();
    cyc(0, 0, "idle");
    zero_timing();

    // WR->RD with tWTR dominating tCCD.
    do_reset();
    t_ccd_m1 = 8'd3; t_wtr_m1 = 8'd7;
    wr_req[1] = 1'b1;
    cyc(3, 1, "wtr_wr");
    wr_req = '0; rd_req[2] = 1'b1;
    for (int c = 1; c < 8; c++) cyc(0, 0, "wtr_block");
    cyc(2, 2, "wtr_rd");
    clr_req();

    // WR->RD with tCCD dominating.
    do_reset();
    t_wtr_m1 = 8'd0;
    wr_req[1] = 1'b1;
    cyc(3, 1, "ccd_wr");
    wr_req = '0; rd_req[2] = 1'b1;
    for (int c = 1; c < 4; c++) cyc(0, 0, "ccd_block");
    cyc(2, 2, "ccd_rd");
    clr_req();
    zero_timing();

    // Mid-operation reset clears a long tRRD.
    do_reset();
    t_rrd_m1 = 8'd5;
    act_req[3] = 1'b1;
    cyc(1, 3, "mid_act");
    act_req = 8'b0100_0000;
    rst = 1'b1;
    cyc(0, 0, "mid_rst");
    rst = 1'b0;
    cyc(1, 6, "mid_after");
    clr_req();
    cyc(0, 0, "idle");
    cyc(0, 0, "idle");

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected commands left, exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sal_cmd_sched.md
# sal_cmd_sched

Per-channel DRAM command scheduler sitting directly downstream of the per-bank controllers. It collects ACT/RD/WR/PRE/REF requests from all bank controllers, enforces inter-bank timing (tRRD, tFAW, tCCD, tWTR, tRTW), and grants at most one command per cycle. Grants return combinationally in the same cycle as the request, which is what the bank FSMs require. The granted command is registered one cycle later toward the DFI/PHY command encoder.

## Interface
Parameters:
- NUM_BK, 8, number of bank controllers (power of two, 2..16)
- RA_W, 16, row address width
- CA_W, 10, column address width
- ID_W, 4, request ID width
- LEN_W, 4, burst length field width
- TW, 8, width of every timing input and internal timing counter

Ports:
- clk  in  1  channel clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- act_req, rd_req, wr_req, pre_req, ref_req  in  NUM_BK each  per-bank request; bit i belongs to bank i
- act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  out  NUM_BK each  per-bank grant, combinational, at most one bit set across all five vectors
- bk_ra  in  NUM_BK*RA_W  per-bank row address; slice i used for ACT
- bk_ca  in  NUM_BK*CA_W  per-bank column address (RD/WR)
- bk_id  in  NUM_BK*ID_W  per-bank request ID (RD/WR)
- bk_len  in  NUM_BK*LEN_W  per-bank burst length (RD/WR)
- t_rrd_m1, t_faw_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  in  TW each  quasi-static timing values minus one
- cmd_valid  out  1  registered command strobe
- cmd_type  out  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE, 5=REF
- cmd_ba  out  log2(NUM_BK)  bank of issued command
- cmd_ra, cmd_ca, cmd_id, cmd_len  out  RA_W/CA_W/ID_W/LEN_W  fields of issued command (zero where unused)

## Operation
- Eligibility: a request is eligible when asserted and its timing checks are met:
  - ACT: rrd_cnt==0 and at least one tFAW slot ==0.
  - RD: ccd_cnt==0 and wtr_cnt==0.
  - WR: ccd_cnt==0 and rtw_cnt==0.
  - PRE and REF: always eligible.
- Class priority: CAS (RD and WR as one class) > PRE > ACT > REF. The highest class with any eligible request wins. Ineligible requests never block a lower class.
- Within a class, selection is round-robin over banks starting at that class's pointer (4 pointers). After a grant, the pointer moves to granted bank+1, wrapping modulo NUM_BK. Pointers of other classes do not change.
- If one bank asserts several requests, class order decides.
- Counters are down-counters saturating at 0. On a grant, a counter loads its value; the following cycle it holds that value and then decrements. A value v therefore separates commands by v+1 cycles.
  - ACT grant loads rrd_cnt with t_rrd_m1. It also loads t_faw_m1 into the lowest-index tFAW slot (of 4) that is zero.
  - RD or WR grant loads ccd_cnt with t_ccd_m1.
  - WR grant loads wtr_cnt with t_wtr_m1.
  - RD grant loads rtw_cnt with t_rtw_m1.
- Output register: on a grant, the next cycle drives cmd_valid=1 plus the type, bank and fields of the granted bank. Otherwise cmd_valid=0 and cmd_type=NOP, with the other fields zero.

## Timing
- Grant latency: 0 cycles, combinational from req/counters/pointers. Command output latency: 1 cycle after grant.
- Throughput: one command per cycle. Back-to-back grants to different classes are legal whenever their timing is met.
- Reset, including mid-operation: all counters, tFAW slots and pointers go to 0; cmd_valid=0; cmd_type=NOP; all cmd fields 0. All grant vectors are forced to 0 while rst=1. Requests pending during reset are granted normally the first cycle after rst drops.
- With timing value 0, the same command class may issue every cycle (e.g. t_ccd_m1=0 gives RD on consecutive cycles).
- Timing inputs are sampled only at grant. A change mid-count does not affect a running counter.
- With all 4 tFAW slots nonzero, every ACT is blocked regardless of rrd_cnt.

## Test plan
- Reset: hold rst=1 with all requests high -> all gnt=0, cmd_valid=0 throughout. Release rst -> next cycle rd_gnt[0]=1 (CAS class, pointer 0).
- Class priority: bank2 act_req, bank5 rd_req, bank7 pre_req in the same cycle -> rd_gnt[5] first, then pre_gnt[7] (bank5 drops req), then act_gnt[2]; cmd_type sequence RD, PRE, ACT one cycle after each grant.
- Round-robin: banks 0..3 continuously assert pre_req -> grants 0,1,2,3,0 on consecutive cycles.
- tRRD/tFAW: t_rrd_m1=1, t_faw_m1=15, banks 0..7 all asserting act_req -> ACT grants at cycles 0,2,4,6; 5th ACT at cycle 16; cmd_ba follows 0,1,2,3,4.
- tWTR/tCCD: t_ccd_m1=3, t_wtr_m1=7, WR granted to bank1 at cycle 0, bank2 rd_req from cycle 1 -> rd_gnt[2] at cycle 8, not earlier. With t_wtr_m1=0 instead -> rd_gnt[2] at cycle 4.
- Mid-operation reset: rst pulsed 1 cycle right after an ACT with t_rrd_m1=5 -> an ACT from another bank is granted the cycle after rst drops.
